// File: rtl/change_dispenser_pkg.sv
// Shared types and change-code constants for the vending FSM and the change dispenser.
package vend_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        EJECT,
        GAP,
        DONE,
        ERR
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        SODA,
        DIME,
        NICKEL
    } coin_t;

    // Change codes count 5-cent units.
    localparam logic [2:0] CHG_0   = 3'd0;
    localparam logic [2:0] CHG_5   = 3'd1;
    localparam logic [2:0] CHG_10  = 3'd2;
    localparam logic [2:0] CHG_15  = 3'd3;
    localparam logic [2:0] CHG_20  = 3'd4;
    localparam logic [2:0] CHG_MAX = CHG_20;

    function automatic logic is_legal_change(input logic [2:0] code);
        return (code <= CHG_MAX);
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Vend request channel from the vending FSM into the change dispenser.
interface change_dispenser_if;

    logic       vend_valid;
    logic       vend_ready;
    logic       soda;
    logic [2:0] change;

    modport master (
        output vend_valid,
        output soda,
        output change,
        input  vend_ready
    );

    modport slave (
        input  vend_valid,
        input  soda,
        input  change,
        output vend_ready
    );

endinterface

// File: rtl/change_dispenser_coin_pulse_timer.sv
// Shared down-counter timing both the eject strobe width and the quiet gap after it.
module coin_pulse_timer
#(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load_pulse,
    input  logic i_load_gap,
    output logic o_expired
);

    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int TW    = (MAX_W > 1) ? $clog2(MAX_W + 1) : 1;

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load_pulse) begin
            r_cnt <= TW'(PULSE_W - 1);
        end else if (i_load_gap) begin
            r_cnt <= TW'(GAP_W - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Output stage after the vending FSM: ejects soda and greedy dime-first change,
// tracks coin inventory and reports any change it could not pay.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_W     = 4,
    parameter int GAP_W       = 2,
    parameter int CNT_W       = 8,
    parameter int NICKEL_INIT = 20,
    parameter int DIME_INIT   = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    change_dispenser_if.slave vend,
    input  logic              i_refill_nickel,
    input  logic              i_refill_dime,
    output logic              o_eject_soda,
    output logic              o_eject_dime,
    output logic              o_eject_nickel,
    output logic              o_done,
    output logic              o_short,
    output logic [2:0]        o_owed,
    output logic              o_err,
    output logic [CNT_W-1:0]  o_nickel_cnt,
    output logic [CNT_W-1:0]  o_dime_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nx;
    coin_t            r_coin;
    coin_t            w_coin_nx;
    logic             r_soda_pend;
    logic             w_soda_pend_nx;
    logic [2:0]       r_amt;
    logic [2:0]       w_amt_nx;
    logic [CNT_W-1:0] r_nickel_cnt;
    logic [CNT_W-1:0] r_dime_cnt;
    logic             w_dec_nickel;
    logic             w_dec_dime;
    logic             w_load_pulse;
    logic             w_load_gap;
    logic             w_expired;

    // A refill coinciding with a decrement cancels out; a lone refill saturates.
    function automatic logic [CNT_W-1:0] f_next_cnt(input logic [CNT_W-1:0] cnt,
                                                    input logic             refill,
                                                    input logic             dec);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (refill && !dec && (cnt != CNT_MAX)) begin
            nxt = cnt + CNT_W'(1);
        end else if (dec && !refill) begin
            nxt = cnt - CNT_W'(1);
        end
        return nxt;
    endfunction

    coin_pulse_timer #(
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W)
    ) u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load_pulse (w_load_pulse),
        .i_load_gap   (w_load_gap),
        .o_expired    (w_expired)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_coin      <= NONE;
            r_soda_pend <= 1'b0;
            r_amt       <= CHG_0;
        end else begin
            r_state     <= w_state_nx;
            r_coin      <= w_coin_nx;
            r_soda_pend <= w_soda_pend_nx;
            r_amt       <= w_amt_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_coin_nx      = r_coin;
        w_soda_pend_nx = r_soda_pend;
        w_amt_nx       = r_amt;
        w_dec_nickel   = 1'b0;
        w_dec_dime     = 1'b0;
        w_load_pulse   = 1'b0;
        w_load_gap     = 1'b0;

        case (r_state)
            IDLE: begin
                if (vend.vend_valid) begin
                    if (is_legal_change(vend.change)) begin
                        w_soda_pend_nx = vend.soda;
                        w_amt_nx       = vend.change;
                        w_coin_nx      = NONE;
                        w_state_nx     = SELECT;
                    end else begin
                        w_state_nx = ERR;
                    end
                end
            end
            SELECT: begin
                w_state_nx   = EJECT;
                w_load_pulse = 1'b1;
                if (r_soda_pend) begin
                    w_coin_nx      = SODA;
                    w_soda_pend_nx = 1'b0;
                end else if ((r_amt >= CHG_10) && (r_dime_cnt != '0)) begin
                    w_coin_nx  = DIME;
                    w_amt_nx   = r_amt - CHG_10;
                    w_dec_dime = 1'b1;
                end else if ((r_amt >= CHG_5) && (r_nickel_cnt != '0)) begin
                    w_coin_nx    = NICKEL;
                    w_amt_nx     = r_amt - CHG_5;
                    w_dec_nickel = 1'b1;
                end else begin
                    w_coin_nx    = NONE;
                    w_state_nx   = DONE;
                    w_load_pulse = 1'b0;
                end
            end
            EJECT: begin
                if (w_expired) begin
                    w_state_nx = GAP;
                    w_load_gap = 1'b1;
                end
            end
            GAP: begin
                if (w_expired) begin
                    w_state_nx = SELECT;
                end
            end
            DONE:    w_state_nx = IDLE;
            ERR:     w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_nickel_cnt <= CNT_W'(NICKEL_INIT);
            r_dime_cnt   <= CNT_W'(DIME_INIT);
        end else begin
            r_nickel_cnt <= f_next_cnt(r_nickel_cnt, i_refill_nickel, w_dec_nickel);
            r_dime_cnt   <= f_next_cnt(r_dime_cnt, i_refill_dime, w_dec_dime);
        end
    end

    assign vend.vend_ready   = (r_state == IDLE);
    assign o_eject_soda      = (r_state == EJECT) && (r_coin == SODA);
    assign o_eject_dime      = (r_state == EJECT) && (r_coin == DIME);
    assign o_eject_nickel    = (r_state == EJECT) && (r_coin == NICKEL);
    assign o_done            = (r_state == DONE);
    assign o_short           = (r_state == DONE) && (r_amt != CHG_0);
    assign o_owed            = (r_state == DONE) ? r_amt : CHG_0;
    assign o_err             = (r_state == ERR);
    assign o_nickel_cnt      = r_nickel_cnt;
    assign o_dime_cnt        = r_dime_cnt;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed corner cases plus random requests
// compared against an item-level model of greedy change payment and inventory.
module tb_change_dispenser;
    import vend_pkg::*;

    localparam int PW  = 2;
    localparam int GW  = 1;
    localparam int CW  = 8;
    localparam int NI  = 20;
    localparam int DI  = 20;
    localparam int MAXC = (1 << CW) - 1;
    localparam logic [2:0] S_SODA   = 3'b100;
    localparam logic [2:0] S_DIME   = 3'b010;
    localparam logic [2:0] S_NICKEL = 3'b001;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_refill_nickel = 1'b0;
    logic          i_refill_dime = 1'b0;
    logic          o_eject_soda;
    logic          o_eject_dime;
    logic          o_eject_nickel;
    logic          o_done;
    logic          o_short;
    logic [2:0]    o_owed;
    logic          o_err;
    logic [CW-1:0] o_nickel_cnt;
    logic [CW-1:0] o_dime_cnt;

    int nCompared = 0;
    int nMismatch = 0;
    int nModel = NI;
    int dModel = DI;

    change_dispenser_if vend_bus ();

    change_dispenser #(
        .PULSE_W     (PW),
        .GAP_W       (GW),
        .CNT_W       (CW),
        .NICKEL_INIT (NI),
        .DIME_INIT   (DI)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .vend            (vend_bus),
        .i_refill_nickel (i_refill_nickel),
        .i_refill_dime   (i_refill_dime),
        .o_eject_soda    (o_eject_soda),
        .o_eject_dime    (o_eject_dime),
        .o_eject_nickel  (o_eject_nickel),
        .o_done          (o_done),
        .o_short         (o_short),
        .o_owed          (o_owed),
        .o_err           (o_err),
        .o_nickel_cnt    (o_nickel_cnt),
        .o_dime_cnt      (o_dime_cnt)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int satInc(input int cnt);
        return (cnt >= MAXC) ? MAXC : cnt + 1;
    endfunction

    task automatic checkOutput(input string tag, input logic [191:0] observed,
                               input logic [191:0] expected);
        nCompared++;
        assert (observed === expected)
        else begin
            nMismatch++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCounts(input string tag);
        checkOutput({tag, " nickels"}, 192'(o_nickel_cnt), 192'(nModel));
        checkOutput({tag, " dimes"}, 192'(o_dime_cnt), 192'(dModel));
    endtask

    task automatic doRefill(input logic rn, input logic rd, input int cycles, input string tag);
        @(negedge i_clk);
        i_refill_nickel = rn;
        i_refill_dime   = rd;
        repeat (cycles) @(negedge i_clk);
        i_refill_nickel = 1'b0;
        i_refill_dime   = 1'b0;
        repeat (cycles) begin
            if (rn) nModel = satInc(nModel);
            if (rd) dModel = satInc(dModel);
        end
        checkCounts(tag);
    endtask

    // Issue one request, then compare the whole strobe timeline and the result against the model.
    task automatic applyStimulus(input logic soda, input logic [2:0] chg,
                                 input bit refillInSelect, input string tag);
        logic [191:0] obsTrace;
        logic [191:0] expTrace;
        logic [2:0]   items[$];
        logic [2:0]   code;
        logic         obsShort;
        logic [2:0]   obsOwed;
        int           a;
        int           waitCyc;
        int           endKind;
        int           expKind;
        int           endCyc;
        int           expCyc;
        int           cyc;
        bit           first;
        bit           sodaPend;

        @(negedge i_clk);
        waitCyc = 0;
        while (vend_bus.vend_ready !== 1'b1 && waitCyc < 64) begin
            @(negedge i_clk);
            waitCyc++;
        end
        checkOutput({tag, " ready before"}, 192'(vend_bus.vend_ready), 192'(1));

        items.delete();
        a = int'(chg);
        expKind = (chg <= CHG_MAX) ? 1 : 2;
        if (expKind == 1) begin
            first = 1'b1;
            sodaPend = soda;
            forever begin
                code = 3'b000;
                if (sodaPend) begin
                    code = S_SODA;
                    sodaPend = 1'b0;
                end else if (a >= 2 && dModel > 0) begin
                    code = S_DIME;
                    a -= 2;
                end else if (a >= 1 && nModel > 0) begin
                    code = S_NICKEL;
                    a -= 1;
                end
                if (first && refillInSelect) begin
                    if (code != S_DIME) dModel = satInc(dModel);
                    if (code != S_NICKEL) nModel = satInc(nModel);
                end else begin
                    if (code == S_DIME) dModel--;
                    if (code == S_NICKEL) nModel--;
                end
                first = 1'b0;
                if (code == 3'b000) break;
                items.push_back(code);
            end
        end

        vend_bus.vend_valid = 1'b1;
        vend_bus.soda       = soda;
        vend_bus.change     = chg;
        @(negedge i_clk);
        vend_bus.vend_valid = 1'b0;
        if (refillInSelect) begin
            i_refill_nickel = 1'b1;
            i_refill_dime   = 1'b1;
        end

        obsTrace = '0;
        endKind  = 0;
        endCyc   = 0;
        obsShort = 1'b0;
        obsOwed  = 3'd0;
        for (int k = 1; k < 64; k++) begin
            obsTrace[3*k +: 3] = {o_eject_soda, o_eject_dime, o_eject_nickel};
            if (o_done === 1'b1) begin
                endKind  = 1;
                endCyc   = k;
                obsShort = o_short;
                obsOwed  = o_owed;
                break;
            end
            if (o_err === 1'b1) begin
                endKind = 2;
                endCyc  = k;
                break;
            end
            @(negedge i_clk);
            i_refill_nickel = 1'b0;
            i_refill_dime   = 1'b0;
        end
        i_refill_nickel = 1'b0;
        i_refill_dime   = 1'b0;

        expTrace = '0;
        expCyc = (expKind == 1) ? items.size() * (1 + PW + GW) + 2 : 1;
        foreach (items[i]) begin
            for (int p = 0; p < PW; p++) begin
                cyc = 1 + i * (1 + PW + GW) + 1 + p;
                expTrace[3*cyc +: 3] = items[i];
            end
        end

        checkOutput({tag, " end kind"}, 192'(endKind), 192'(expKind));
        checkOutput({tag, " end cycle"}, 192'(endCyc), 192'(expCyc));
        checkOutput({tag, " strobe trace"}, obsTrace, expTrace);
        if (expKind == 1) begin
            checkOutput({tag, " short"}, 192'(obsShort), 192'(a != 0));
            checkOutput({tag, " owed"}, 192'(obsOwed), 192'(a));
        end
        checkCounts(tag);
        @(negedge i_clk);
        checkOutput({tag, " ready after"}, 192'(vend_bus.vend_ready), 192'(1));
    endtask

    initial begin
        logic       rs;
        logic [2:0] rc;

        vend_bus.vend_valid = 1'b0;
        vend_bus.soda       = 1'b0;
        vend_bus.change     = 3'd0;

        $display("[TB] reset");
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("reset strobes", 192'({o_eject_soda, o_eject_dime, o_eject_nickel}), 192'(0));
        checkOutput("reset ready", 192'(vend_bus.vend_ready), 192'(1));
        checkOutput("reset owed", 192'(o_owed), 192'(0));
        checkOutput("reset flags", 192'({o_done, o_short, o_err}), 192'(0));
        checkCounts("reset");
        i_rst_n = 1'b1;

        $display("[TB] directed requests");
        applyStimulus(1'b1, CHG_15, 1'b0, "soda+15");
        applyStimulus(1'b0, CHG_10, 1'b1, "refill in select");
        applyStimulus(1'b1, 3'd6, 1'b0, "illegal 6");
        applyStimulus(1'b0, CHG_0, 1'b0, "empty request");
        applyStimulus(1'b0, 3'd7, 1'b0, "illegal 7");

        $display("[TB] random requests");
        for (int r = 0; r < 16; r++) begin
            rs = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            if ($urandom_range(0, 2) == 0) begin
                doRefill(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         $urandom_range(1, 3), "random refill");
            end
            applyStimulus(rs, rc, 1'b0, "random");
        end

        $display("[TB] drain stock");
        while (dModel > 0) applyStimulus(1'b0, CHG_20, 1'b0, "drain dimes");
        if (nModel < 3) doRefill(1'b1, 1'b0, 3 - nModel, "nickel top-up");
        while (nModel > 3) applyStimulus(1'b0, CHG_5, 1'b0, "drain nickels");
        applyStimulus(1'b0, CHG_20, 1'b0, "short 20");
        applyStimulus(1'b0, CHG_10, 1'b0, "empty stock");

        $display("[TB] saturation");
        doRefill(1'b1, 1'b0, 260, "nickel saturate");
        doRefill(1'b1, 1'b0, 1, "nickel at max");
        doRefill(1'b0, 1'b1, 2, "dime top-up");

        $display("[TB] reset during dime strobe");
        @(negedge i_clk);
        vend_bus.vend_valid = 1'b1;
        vend_bus.soda       = 1'b0;
        vend_bus.change     = CHG_10;
        @(negedge i_clk);
        vend_bus.vend_valid = 1'b0;
        @(negedge i_clk);
        checkOutput("mid-reset strobe c1", 192'({o_eject_soda, o_eject_dime, o_eject_nickel}), 192'(S_DIME));
        @(negedge i_clk);
        checkOutput("mid-reset strobe c2", 192'({o_eject_soda, o_eject_dime, o_eject_nickel}), 192'(S_DIME));
        i_rst_n = 1'b0;
        @(negedge i_clk);
        nModel = NI;
        dModel = DI;
        checkOutput("mid-reset strobes low", 192'({o_eject_soda, o_eject_dime, o_eject_nickel}), 192'(0));
        checkOutput("mid-reset ready", 192'(vend_bus.vend_ready), 192'(1));
        checkCounts("mid-reset");
        i_rst_n = 1'b1;
        applyStimulus(1'b1, CHG_15, 1'b0, "after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
